// File: rtl/score_scan.sv
// Binary-to-BCD score display: sequential double-dabble converter feeding a
// four-digit multiplexed scan. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module score_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] score,
    input  logic        load,
    output logic        busy,
    output logic [7:0]  digit,
    output logic [3:0]  an
);
    // state | meaning
    // IDLE  | display stable, waiting for a load strobe
    // CONV  | 14 double-dabble steps in flight, load ignored
    typedef enum logic {IDLE, CONV} state_t;

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t         state_q, state_d;
    logic [3:0]     step_q, step_d;
    logic [13:0]    bin_q, bin_d;
    logic [15:0]    bcd_q, bcd_d;
    logic [15:0]    disp_q, disp_d;
    logic [CW-1:0]  ref_q, ref_d;
    logic [1:0]     sel_q, sel_d;
    logic [3:0]     an_q, an_d;
    logic [7:0]     digit_q, digit_d;
    logic [15:0]    adj;
    logic [15:0]    shifted;
    logic [1:0]     msd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            bin_q   <= 14'd0;
            bcd_q   <= 16'd0;
            disp_q  <= 16'd0;
            ref_q   <= '0;
            sel_q   <= 2'd0;
            an_q    <= 4'b1110;
            digit_q <= 8'h00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            ref_q   <= ref_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            adj[k*4 +: 4] = (bcd_q[k*4 +: 4] >= 4'd5) ? bcd_q[k*4 +: 4] + 4'd3
                                                       : bcd_q[k*4 +: 4];
        end
        shifted = {adj[14:0], bin_q[13]};
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = (score > 14'd9999) ? 14'd9999 : score;
                    bcd_d   = 16'd0;
                    step_d  = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d  = shifted;
                bin_d  = {bin_q[12:0], 1'b0};
                step_d = step_q + 4'd1;
                // final step lands directly in the display so it never sees a partial value
                if (step_q == 4'd13) begin
                    disp_d  = shifted;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (disp_d[15:12] != 4'd0)     msd = 2'd3;
        else if (disp_d[11:8] != 4'd0) msd = 2'd2;
        else if (disp_d[7:4] != 4'd0)  msd = 2'd1;
        else                           msd = 2'd0;
    end

    // an/digit are computed from next-cycle select and display so they move together with them
    always_comb begin
        if (ref_q == CW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            sel_d = sel_q + 2'd1;
        end else begin
            ref_d = ref_q + 1'b1;
            sel_d = sel_q;
        end
        an_d    = ~(4'b0001 << sel_d);
        digit_d = {4'b0000, disp_d[{sel_d, 2'b00} +: 4]};
`ifdef LEADING_ZERO_BLANK_EN
        if (sel_d > msd) an_d = 4'b1111;
`endif
    end

    assign busy  = (state_q == CONV);
    assign an    = an_q;
    assign digit = digit_q;

endmodule
